// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the alignment rule applied when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = offset[0];
      SIZE_W:  mis = |offset[1:0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts and extends a load from a little-endian
// dword, and merges store data into a dword for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] mem_dword,
  input  logic [2:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] bit_mask;
  logic [7:0]        size_mask;
  logic [7:0]        lane_mask;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;
  logic signed [31:0] lane_w;

  always_comb begin
    shifted   = mem_dword >> {offset, 3'b000};
    lane_b    = shifted[7:0];
    lane_h    = shifted[15:0];
    lane_w    = shifted[31:0];
    load_data = shifted;
    case (size)
      SIZE_B:  load_data = is_signed ? {{(DATA_W-8){lane_b[7]}}, lane_b}
                                     : {{(DATA_W-8){1'b0}}, lane_b};
      SIZE_H:  load_data = is_signed ? {{(DATA_W-16){lane_h[15]}}, lane_h}
                                     : {{(DATA_W-16){1'b0}}, lane_h};
      SIZE_W:  load_data = is_signed ? {{(DATA_W-32){lane_w[31]}}, lane_w}
                                     : {{(DATA_W-32){1'b0}}, lane_w};
      default: load_data = shifted;
    endcase
  end

  // A dword store uses a full lane mask, so the merge passes wdata straight through.
  always_comb begin
    case (size)
      SIZE_B:  size_mask = 8'h01;
      SIZE_H:  size_mask = 8'h03;
      SIZE_W:  size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    lane_mask = size_mask << offset;
    bit_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
    wdata_sh   = wdata << {offset, 3'b000};
    merge_data = (mem_dword & ~bit_mask) | (wdata_sh & bit_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and a dword-wide
// data memory; sub-dword stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wrt_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        state, state_nxt;
  logic              accept;
  logic              is_store_p0;
  logic              fault_p0;
  logic              signed_p0;
  logic [1:0]        size_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  assign accept = req_valid && (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      is_store_p0 <= 1'b0;
      fault_p0    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_store_p0 <= req_is_store;
        fault_p0    <= is_misaligned(req_size, req_addr[2:0]);
      end
    end
  end

  // Stage p0: request capture; stage p1: memory dword captured at the end of RD.
  always_ff @(posedge clk) begin
    if (accept) begin
      size_p0   <= req_size;
      signed_p0 <= req_signed;
      addr_p0   <= req_addr;
      wdata_p0  <= req_wdata;
    end
    if (state == RD) begin
      rdata_p1 <= mem_read_data;
    end
  end

  lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .mem_dword  (rdata_p1),
    .offset     (addr_p0[2:0]),
    .size       (size_p0),
    .is_signed  (signed_p0),
    .wdata      (wdata_p0),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wrt_data = '0;
    resp_valid   = 1'b0;
    resp_fault   = 1'b0;
    resp_data    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[2:0])) state_nxt = RESP;
          else if (req_is_store && (req_size == SIZE_D)) state_nxt = WR;
          else state_nxt = RD;
        end
      end
      RD: begin
        mem_read    = 1'b1;
        mem_address = {addr_p0[ADDR_W-1:3], 3'b000};
        state_nxt   = is_store_p0 ? WR : RESP;
      end
      WR: begin
        mem_write    = 1'b1;
        mem_address  = {addr_p0[ADDR_W-1:3], 3'b000};
        mem_wrt_data = merge_data;
        state_nxt    = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        resp_fault = fault_p0;
        if (!fault_p0 && !is_store_p0) resp_data = load_data;
        state_nxt  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 128-byte memory attached to the DUT and a
// byte-level reference model that predicts every response and the final memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_fault;
  logic [63:0] mem_address;
  logic [63:0] mem_wrt_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_fault    (resp_fault),
    .mem_address   (mem_address),
    .mem_wrt_data  (mem_wrt_data),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .mem_read_data (mem_read_data)
  );

  // Attached memory: 16 dwords, preloaded through pre_* while the DUT is idle.
  logic [63:0] env_mem [16];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [63:0] pre_val;

  assign mem_read_data = env_mem[mem_address[6:3]];

  always @(posedge clk) begin
    if (mem_write) env_mem[mem_address[6:3]] <= mem_wrt_data;
    else if (pre_we) env_mem[pre_idx] <= pre_val;
  end

  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, resp_cnt = 0, bad_addr_cnt = 0;
  logic [63:0] last_wr_addr = '0;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_cnt++;
      last_wr_addr = mem_address;
    end
    if (mem_read) rd_cnt++;
    if (mem_read && mem_write) both_cnt++;
    if (mem_address[2:0] != 3'b000) bad_addr_cnt++;
    if (resp_valid) resp_cnt++;
  end

  // Reference model: plain byte array, little-endian.
  logic [7:0] ref_bytes [128];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_load(input int a, input int sz, input logic sg);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[a+i];
    if (sg && n < 8 && v[8*n-1]) begin
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_dword(input int idx);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_bytes[8*idx+i];
    return v;
  endfunction

  // Runs one request from an idle negedge; returns at the negedge after RESP.
  task automatic txn(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                     input int a, input logic [63:0] wd, output logic [63:0] data);
    int n, lat, exp_lat, wr0, rd0;
    logic flt, exp_flt;
    logic [63:0] exp_data;
    n       = 1 << sz;
    exp_flt = (a % n) != 0;
    exp_lat = exp_flt ? 1 : (!st ? 2 : (sz == 2'b11 ? 2 : 3));
    exp_data = (exp_flt || st) ? 64'd0 : ref_load(a, int'(sz), sg);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    check({tag, ".ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_signed = sg;
    req_addr = 64'(a); req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    data = resp_data;
    flt  = resp_fault;
    check({tag, ".lat"},   64'(lat), 64'(exp_lat));
    check({tag, ".fault"}, {63'd0, flt}, {63'd0, exp_flt});
    check({tag, ".data"},  data, exp_data);
    check({tag, ".nwr"},   64'(wr_cnt - wr0), (st && !exp_flt) ? 64'd1 : 64'd0);
    check({tag, ".nrd"},   64'(rd_cnt - rd0),
          (!exp_flt && (!st || sz != 2'b11)) ? 64'd1 : 64'd0);
    if (st && !exp_flt) begin
      for (int i = 0; i < n; i++) ref_bytes[a+i] = wd[8*i +: 8];
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d, d1, d2, e1, e2;
    int wr0, resp0, t1, t2, rdy_cyc, nresp;

    reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      pre_we = 1'b1; pre_idx = 4'(i); pre_val = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_bytes[8*i+b] = pre_val[8*b +: 8];
      @(negedge clk);
    end
    pre_we = 1'b0;

    check("rst.ready",  {63'd0, req_ready},  64'd1);
    check("rst.rvalid", {63'd0, resp_valid}, 64'd0);
    check("rst.rd",     {63'd0, mem_read},   64'd0);
    check("rst.wr",     {63'd0, mem_write},  64'd0);
    check("rst.addr",   mem_address, 64'd0);
    check("rst.rdata",  resp_data,   64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Dword store then load back.
    wr0 = wr_cnt;
    txn("st_d16", 1'b1, 2'b11, 1'b0, 16, 64'd3, d);
    check("st_d16.addr", last_wr_addr, 64'd16);
    check("st_d16.pulses", 64'(wr_cnt - wr0), 64'd1);
    txn("ld_d16", 1'b0, 2'b11, 1'b1, 16, 64'd0, d);
    check("ld_d16.val", d, 64'd3);

    // Signed and unsigned byte load of 0xF0.
    txn("st_d8", 1'b1, 2'b11, 1'b0, 8, 64'h0000_0000_0000_00F0, d);
    txn("ld_bs", 1'b0, 2'b00, 1'b1, 8, 64'd0, d);
    check("ld_bs.val", d, 64'hFFFF_FFFF_FFFF_FFF0);
    txn("ld_bu", 1'b0, 2'b00, 1'b0, 8, 64'd0, d);
    check("ld_bu.val", d, 64'h0000_0000_0000_00F0);

    // Half store into the middle of a dword (read-modify-write).
    txn("st_d0", 1'b1, 2'b11, 1'b0, 0, 64'h1122_3344_5566_7788, d);
    txn("st_h2", 1'b1, 2'b01, 1'b0, 2, 64'h0000_0000_0000_AABB, d);
    @(negedge clk);
    check("st_h2.mem", env_mem[0], 64'h1122_3344_AABB_7788);
    check("st_h2.addr", last_wr_addr, 64'd0);

    // Misaligned word load.
    txn("ld_w6", 1'b0, 2'b10, 1'b0, 6, 64'd0, d);

    // Reset while in RD of a byte store.
    wr0 = wr_cnt; resp0 = resp_cnt;
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 64'd5; req_wdata = 64'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstrd.inrd", {63'd0, mem_read}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("rstrd.ready", {63'd0, req_ready}, 64'd1);
    check("rstrd.rd",    {63'd0, mem_read},  64'd0);
    check("rstrd.addr",  mem_address, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstrd.nwr",   64'(wr_cnt - wr0), 64'd0);
    check("rstrd.nresp", 64'(resp_cnt - resp0), 64'd0);
    check("rstrd.mem",   env_mem[0], ref_dword(0));
    check("rstrd.ready2", {63'd0, req_ready}, 64'd1);

    // Two loads with req_valid held high throughout.
    e1 = ref_load(16, 3, 1'b0);
    e2 = ref_load(36, 2, 1'b1);
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'b11; req_signed = 1'b0;
    req_addr = 64'd16;
    @(posedge clk);
    @(negedge clk);
    req_size = 2'b10; req_signed = 1'b1; req_addr = 64'd36;
    t1 = 0; t2 = 0; rdy_cyc = 0; nresp = 0; d1 = '0; d2 = '0;
    for (int k = 1; k <= 10; k++) begin
      if (resp_valid) begin
        if (nresp == 0) begin t1 = k; d1 = resp_data; end
        else begin t2 = k; d2 = resp_data; end
        nresp++;
      end
      if (req_ready && rdy_cyc == 0) rdy_cyc = k;
      if (rdy_cyc != 0 && k == rdy_cyc + 1) req_valid = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b.nresp", 64'(nresp), 64'd2);
    check("b2b.t1",    64'(t1), 64'd2);
    check("b2b.rdy",   64'(rdy_cyc), 64'd3);
    check("b2b.t2",    64'(t2), 64'd5);
    check("b2b.d1",    d1, e1);
    check("b2b.d2",    d2, e2);

    // Random traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] sz;
      int a;
      sz = 2'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
      txn("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
          {$urandom, $urandom}, d);
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) check("final.mem", env_mem[i], ref_dword(i));
    check("rd_wr_overlap", 64'(both_cnt), 64'd0);
    check("unaligned_addr", 64'(bad_addr_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
